dipsw_debounce: RTL and testbench

- Conditions the raw DIP-switch pins before they reach the switch PIO's in_port.
- Synchronises each asynchronous pin with 2 flops, then debounces it with its own counter and 2-state FSM.
- Drives the debounced vector to the PIO, so PIO edge capture fires once per real switch change, never on contact bounce.
- Adds per-bit change pulses and an all-stable flag for status use.

---
 rtl/dipsw_debounce.sv | 121 ++++++++++++
 tb/tb_dipsw_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dipsw_debounce.sv
// DIP-switch conditioner: 2-flop synchroniser plus an independent debounce
// filter per bit, with change pulses and an all-stable status flag.
//
// state | meaning
// IDLE  | sample agrees with sw_out, counter held at 0
// COUNT | sample disagrees with sw_out, counting consecutive mismatches
module dipsw_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             bypass,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_changed,
  output logic             sw_stable
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_TC  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam bit                   SINGLE  = (DEBOUNCE_CYCLES == 1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  state_t               state_q [WIDTH];
  state_t               state_d [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_q   [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0]     out_d;
  logic [WIDTH-1:0]     changed_d;
  logic                 stable_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      sw_out     <= RESET_VALUE;
      sw_changed <= '0;
      sw_stable  <= 1'b1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sw_out     <= out_d;
      sw_changed <= changed_d;
      sw_stable  <= stable_d;
    end
  end

  always_comb begin
    out_d     = sw_out;
    changed_d = '0;
    stable_d  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (bypass) begin
        // Pending counts are dropped; the output follows the synchronised pin.
        state_d[i]   = IDLE;
        cnt_d[i]     = '0;
        out_d[i]     = sync2[i];
        changed_d[i] = sync2[i] ^ sw_out[i];
      end else begin
        case (state_q[i])
          IDLE: begin
            cnt_d[i] = '0;
            if (sync2[i] != sw_out[i]) begin
              if (SINGLE) begin
                out_d[i]     = sync2[i];
                changed_d[i] = 1'b1;
              end else begin
                state_d[i] = COUNT;
                cnt_d[i]   = CNT_ONE;
              end
            end
          end
          COUNT: begin
            if (sync2[i] == sw_out[i]) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_TC) begin
              out_d[i]     = sync2[i];
              changed_d[i] = 1'b1;
              state_d[i]   = IDLE;
              cnt_d[i]     = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      if (state_d[i] != IDLE) stable_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_dipsw_debounce.sv
// Directed bench for dipsw_debounce with DEBOUNCE_CYCLES=8: one vector table
// plus hand-written bounce and reset-mid-count sequences.
module tb_dipsw_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_in;
  logic       bypass;
  logic [3:0] sw_out;
  logic [3:0] sw_changed;
  logic       sw_stable;

  int n_vec = 0;
  int n_err = 0;

  dipsw_debounce #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH(16),
    .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_in(sw_in),
    .bypass(bypass),
    .sw_out(sw_out),
    .sw_changed(sw_changed),
    .sw_stable(sw_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic       byp;
    logic       rst_n;
    logic [3:0] out;
    logic [3:0] chg;
    logic       stb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic [3:0] sw, input logic byp,
                              input logic rst_n, input logic [3:0] out,
                              input logic [3:0] chg, input logic stb);
    vec_t v;
    v.sw = sw; v.byp = byp; v.rst_n = rst_n; v.out = out; v.chg = chg; v.stb = stb;
    for (int j = 0; j < n; j++) vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eo, input logic [3:0] ec,
                       input logic es, input bit use_stb);
    n_vec++;
    if (sw_out !== eo || sw_changed !== ec || (use_stb && sw_stable !== es)) begin
      n_err++;
      $display("FAIL %s: got out=%h chg=%h stb=%b, expected out=%h chg=%h stb=%b",
               name, sw_out, sw_changed, sw_stable, eo, ec, es);
    end
  endtask

  initial begin
    sw_in   = 4'hF;
    bypass  = 1'b0;
    reset_n = 1'b0;

    // reset held with all pins high, then released with pins low
    add(3,  4'hF, 0, 0, 4'h0, 4'h0, 1);
    add(50, 4'h0, 0, 1, 4'h0, 4'h0, 1);
    // clean rise of bit 0
    add(2,  4'h1, 0, 1, 4'h0, 4'h0, 1);
    add(7,  4'h1, 0, 1, 4'h0, 4'h0, 0);
    add(1,  4'h1, 0, 1, 4'h1, 4'h1, 1);
    add(5,  4'h1, 0, 1, 4'h1, 4'h0, 1);
    // bits 2 and 3 rise together, bit 2 reverts 20 edges later
    add(2,  4'hD, 0, 1, 4'h1, 4'h0, 1);
    add(7,  4'hD, 0, 1, 4'h1, 4'h0, 0);
    add(1,  4'hD, 0, 1, 4'hD, 4'hC, 1);
    add(10, 4'hD, 0, 1, 4'hD, 4'h0, 1);
    add(2,  4'h9, 0, 1, 4'hD, 4'h0, 1);
    add(7,  4'h9, 0, 1, 4'hD, 4'h0, 0);
    add(1,  4'h9, 0, 1, 4'h9, 4'h4, 1);
    add(5,  4'h9, 0, 1, 4'h9, 4'h0, 1);
    // bypass: output follows the synchroniser two edges after capture
    add(2,  4'h5, 1, 1, 4'h9, 4'h0, 1);
    add(1,  4'h5, 1, 1, 4'h5, 4'hC, 1);
    add(3,  4'h5, 1, 1, 4'h5, 4'h0, 1);
    // bypass exit: no pulse, then full latency for bit 0 falling
    add(5,  4'h5, 0, 1, 4'h5, 4'h0, 1);
    add(2,  4'h4, 0, 1, 4'h5, 4'h0, 1);
    add(7,  4'h4, 0, 1, 4'h5, 4'h0, 0);
    add(1,  4'h4, 0, 1, 4'h4, 4'h1, 1);
    add(3,  4'h4, 0, 1, 4'h4, 4'h0, 1);
    // bypass entered while bit 1 is counting
    add(2,  4'h6, 0, 1, 4'h4, 4'h0, 1);
    add(3,  4'h6, 0, 1, 4'h4, 4'h0, 0);
    add(1,  4'h6, 1, 1, 4'h6, 4'h2, 1);
    add(2,  4'h6, 1, 1, 4'h6, 4'h0, 1);
    add(11, 4'h6, 0, 1, 4'h6, 4'h0, 1);

    foreach (vecs[i]) begin
      sw_in   = vecs[i].sw;
      bypass  = vecs[i].byp;
      reset_n = vecs[i].rst_n;
      tick();
      check($sformatf("vec%0d", i), vecs[i].out, vecs[i].chg, vecs[i].stb, 1'b1);
    end

    // clean restart for the hand-written sequences
    sw_in   = 4'h0;
    bypass  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset", 4'h0, 4'h0, 1'b1, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("post_reset_idle", 4'h0, 4'h0, 1'b1, 1'b1);
    end

    // bit 1 bounces: 3 high / 2 low, five times, then holds high
    for (int p = 0; p < 5; p++) begin
      for (int t = 0; t < 5; t++) begin
        sw_in = (t < 3) ? 4'h2 : 4'h0;
        tick();
        check("bounce_hold", 4'h0, 4'h0, 1'b0, 1'b0);
      end
    end
    sw_in = 4'h2;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t < 10)       check("bounce_wait",  4'h0, 4'h0, (t <= 2), 1'b1);
      else if (t == 10) check("bounce_accept", 4'h2, 4'h2, 1'b1, 1'b1);
      else              check("bounce_after", 4'h2, 4'h0, 1'b1, 1'b1);
    end

    // reset arrives while bit 3 is counting
    sw_in = 4'hA;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("pre_reset_count", 4'h2, 4'h0, (t <= 2), 1'b1);
    end
    reset_n = 1'b0;
    #1;
    check("mid_count_reset", 4'h0, 4'h0, 1'b1, 1'b1);
    for (int t = 0; t < 2; t++) begin
      tick();
      check("mid_count_held", 4'h0, 4'h0, 1'b1, 1'b1);
    end
    reset_n = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t < 10)       check("post_release_wait",   4'h0, 4'h0, (t <= 2), 1'b1);
      else if (t == 10) check("post_release_accept", 4'hA, 4'hA, 1'b1, 1'b1);
      else              check("post_release_after",  4'hA, 4'h0, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
